// File: rtl/imm_gen.sv
// imm_gen: RV32I decode-stage immediate generator.
// Extracts and sign-extends the I, S, B or J immediate from the instruction
// word as chosen by immSel, and registers the result with a valid flag
// (one cycle latency, one result per cycle).
// Optional feature macro: IMMGEN_UTYPE_EN adds the uSel port and the U-type
// immediate {i[31:12], 12'h000}, which takes precedence over immSel.
module imm_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] instruction,
    input  logic [1:0]  immSel,
`ifdef IMMGEN_UTYPE_EN
    input  logic        uSel,
`endif
    output logic [31:0] Imm,
    output logic        out_valid
);

    // Format select encodings.
    localparam logic [1:0] SEL_I = 2'b00;
    localparam logic [1:0] SEL_S = 2'b01;
    localparam logic [1:0] SEL_B = 2'b10;
    localparam logic [1:0] SEL_J = 2'b11;

    // I-type: 12-bit immediate in the top field.
    function automatic logic [31:0] imm_i(input logic [31:0] i);
        imm_i = {{20{i[31]}}, i[31:20]};
    endfunction

    // S-type: immediate split between funct7 and rd positions.
    function automatic logic [31:0] imm_s_fmt(input logic [31:0] i);
        imm_s_fmt = {{20{i[31]}}, i[31:25], i[11:7]};
    endfunction

    // B-type: branch offset, always even.
    function automatic logic [31:0] imm_b(input logic [31:0] i);
        imm_b = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    // J-type: jump offset, always even.
    function automatic logic [31:0] imm_j(input logic [31:0] i);
        imm_j = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

`ifdef IMMGEN_UTYPE_EN
    // U-type: upper 20 bits, low 12 bits cleared.
    function automatic logic [31:0] imm_u(input logic [31:0] i);
        imm_u = {i[31:12], 12'h000};
    endfunction
`endif

    logic [31:0] imm_s;
    logic [31:0] imm_r;
    logic        valid_r;

    // Opcode bits never contribute to any immediate.
    logic unused_s;
    assign unused_s = ^instruction[6:0];

    // Select the immediate format for the current instruction word.
    always_comb begin
        imm_s = 32'h0000_0000;
`ifdef IMMGEN_UTYPE_EN
        if (uSel) begin
            imm_s = imm_u(instruction);
        end else begin
`endif
            case (immSel)
                SEL_I:   imm_s = imm_i(instruction);
                SEL_S:   imm_s = imm_s_fmt(instruction);
                SEL_B:   imm_s = imm_b(instruction);
                SEL_J:   imm_s = imm_j(instruction);
                default: imm_s = imm_i(instruction);
            endcase
`ifdef IMMGEN_UTYPE_EN
        end
`endif
    end

    // Output register: reset clears, accepted instruction captures, idle holds Imm.
    always_ff @(posedge clk) begin
        if (rst) begin
            imm_r   <= 32'h0000_0000;
            valid_r <= 1'b0;
        end else if (in_valid) begin
            imm_r   <= imm_s;
            valid_r <= 1'b1;
        end else begin
            imm_r   <= imm_r;
            valid_r <= 1'b0;
        end
    end

    assign Imm       = imm_r;
    assign out_valid = valid_r;

endmodule

// File: tb/tb_imm_gen.sv
// tb_imm_gen: directed-vector scoreboard bench for imm_gen.
// The driver pushes one expectation per clock cycle; the monitor pops and
// compares out_valid and Imm one step after each rising edge.
module tb_imm_gen;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] instruction;
    logic [1:0]  immSel;
`ifdef IMMGEN_UTYPE_EN
    logic        uSel;
`endif
    logic [31:0] Imm;
    logic        out_valid;

    typedef struct {
        logic        vld;
        logic [31:0] imm;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp;
    int          n_bad;
    logic [31:0] held_imm;

    imm_gen dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .instruction (instruction),
        .immSel      (immSel),
`ifdef IMMGEN_UTYPE_EN
        .uSel        (uSel),
`endif
        .Imm         (Imm),
        .out_valid   (out_valid)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of stimulus on the falling edge and queue its expectation.
    task automatic step(input logic r, input logic v, input logic [1:0] sel,
                        input logic us, input logic [31:0] instr,
                        input logic [31:0] exp_imm, input string name);
        exp_t e;
        @(negedge clk);
        rst         = r;
        in_valid    = v;
        immSel      = sel;
        instruction = instr;
`ifdef IMMGEN_UTYPE_EN
        uSel        = us;
`else
        if (us) $display("note: U-type vector issued without IMMGEN_UTYPE_EN");
`endif
        if (r) begin
            held_imm = 32'h0000_0000;
            e.vld    = 1'b0;
        end else if (v) begin
            held_imm = exp_imm;
            e.vld    = 1'b1;
        end else begin
            e.vld    = 1'b0;
        end
        e.imm  = held_imm;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Monitor: pop the expectation for each edge and compare both outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (out_valid !== e.vld) begin
                    n_bad++;
                    $display("FAIL %s out_valid: got %b expected %b", e.name, out_valid, e.vld);
                end
                n_cmp++;
                if (Imm !== e.imm) begin
                    n_bad++;
                    $display("FAIL %s Imm: got %08h expected %08h", e.name, Imm, e.imm);
                end
            end
        end
    end

    // Stimulus sequence and end-of-test drain.
    initial begin
        int wait_cyc;
        n_cmp       = 0;
        n_bad       = 0;
        held_imm    = 32'h0000_0000;
        rst         = 1'b1;
        in_valid    = 1'b0;
        immSel      = 2'b00;
        instruction = 32'h0000_0000;
`ifdef IMMGEN_UTYPE_EN
        uSel        = 1'b0;
`endif
        // Reset for two cycles, then reset wins over a valid instruction.
        step(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0000, 32'h0000_0000, "reset0");
        step(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0000, 32'h0000_0000, "reset1");
        step(1'b1, 1'b1, 2'b00, 1'b0, 32'h7FF0_0000, 32'h0000_0000, "reset_prio");
        step(1'b0, 1'b0, 2'b11, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, "idle_after_rst");
        // I, S, B, J back to back.
        step(1'b0, 1'b1, 2'b00, 1'b0, 32'h7FF0_0000, 32'h0000_07FF, "i_pos");
        step(1'b0, 1'b1, 2'b00, 1'b0, 32'h8000_0000, 32'hFFFF_F800, "i_neg");
        step(1'b0, 1'b1, 2'b01, 1'b0, 32'h0070_A223, 32'h0000_0004, "s_sw");
        step(1'b0, 1'b1, 2'b01, 1'b0, 32'h7F00_0F80, 32'h0000_07FF, "s_max");
        step(1'b0, 1'b1, 2'b10, 1'b0, 32'h3F00_0F00, 32'h0000_03FE, "b_pos");
        step(1'b0, 1'b1, 2'b10, 1'b0, 32'h8000_0080, 32'hFFFF_F800, "b_neg");
        step(1'b0, 1'b1, 2'b11, 1'b0, 32'h007F_F0EF, 32'h000F_F806, "j_pos");
        step(1'b0, 1'b1, 2'b11, 1'b0, 32'hFFFF_F00F, 32'hFFFF_FFFE, "j_neg");
        // Hold: inputs change with in_valid low.
        step(1'b0, 1'b0, 2'b00, 1'b0, 32'h1234_5678, 32'h0000_0000, "hold0");
        step(1'b0, 1'b0, 2'b01, 1'b0, 32'h7F00_0F80, 32'h0000_0000, "hold1");
        // A valid result, then reset clears it.
        step(1'b0, 1'b1, 2'b00, 1'b0, 32'h7FF0_0000, 32'h0000_07FF, "i_again");
        step(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0000, 32'h0000_0000, "reset_mid");
        step(1'b0, 1'b1, 2'b10, 1'b0, 32'h8000_0080, 32'hFFFF_F800, "b_after_rst");
`ifdef IMMGEN_UTYPE_EN
        step(1'b0, 1'b1, 2'b10, 1'b1, 32'h1234_5037, 32'h1234_5000, "u_lui");
        step(1'b0, 1'b1, 2'b00, 1'b0, 32'h1234_5037, 32'h0000_0123, "u_off_i");
`endif
        step(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0000, 32'h0000_0000, "final_idle");

        // Drain the scoreboard within a bounded number of cycles.
        wait_cyc = 0;
        while (sb_q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
